// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scheduler: EX operand-mux select codes and FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_RSVD = 2'b11
  } fwd_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LD_STALL = 2'b01,
    FROZEN   = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_scheduler_if.sv
// ID-stage request, pipeline status and hazard-control response bundle of the hazard scheduler.
interface hazard_scheduler_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_branch_taken;
  logic              mem_busy;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              freeze;
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           ex_branch_taken, mem_busy,
    input  fwd_a_sel, fwd_b_sel, stall_pc, stall_if_id, flush_if_id,
           flush_id_ex, freeze, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           ex_branch_taken, mem_busy,
    output fwd_a_sel, fwd_b_sel, stall_pc, stall_if_id, flush_if_id,
           flush_id_ex, freeze, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_stage_track.sv
// Two-entry destination tracker: entry 0 = ID/EX, entry 1 = EX/MEM.
// hold freezes both entries; clear loads a bubble into ID/EX as the pair shifts.
module hazard_stage_track #(
  parameter int AW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               clear,
  input  logic [AW-1:0]      in_rd,
  input  logic               in_we,
  input  logic               in_ld,
  output logic [1:0][AW-1:0] rd,
  output logic [1:0]         we,
  output logic [1:0]         ld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      we <= '0;
      ld <= '0;
    end else if (!hold) begin
      rd[1] <= rd[0];
      we[1] <= we[0];
      ld[1] <= ld[0];
      if (clear) begin
        rd[0] <= '0;
        we[0] <= 1'b0;
        ld[0] <= 1'b0;
      end else begin
        rd[0] <= in_rd;
        we[0] <= in_we;
        ld[0] <= in_ld;
      end
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Forwarding-select, load-use stall, branch-flush and freeze control for a 5-stage pipeline.
// Define HAZARD_PERF_EN to build the saturating stall/flush event counters.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  hazard_scheduler_if.slave hif
);

  logic [1:0][REG_AW-1:0] trk_rd;
  logic [1:0]             trk_we;
  logic [1:0]             trk_ld;
  hz_state_e              state, prev_state, eff_state;
  logic                   br_pend, br, lu, lu_raw, frz;
  fwd_e                   sel_a, sel_b, sel_a_q, sel_b_q;

  assign frz = hif.mem_busy;

  hazard_stage_track #(.AW(REG_AW)) u_track (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (frz),
    .clear (hif.flush_id_ex),
    .in_rd (hif.id_rd),
    .in_we (hif.id_valid & hif.id_reg_write),
    .in_ld (hif.id_valid & hif.id_mem_read),
    .rd    (trk_rd),
    .we    (trk_we),
    .ld    (trk_ld)
  );

  // Leaving FROZEN, decisions are made as if in the state we froze from.
  assign eff_state = (state == FROZEN) ? prev_state : state;
  assign br        = !frz && (hif.ex_branch_taken || br_pend);
  assign lu_raw    = hif.id_valid && trk_ld[0] && trk_we[0] && (trk_rd[0] != '0) &&
                     ((hif.id_rs1 == trk_rd[0]) || (hif.id_rs2 == trk_rd[0]));
  assign lu        = !frz && !br && (eff_state == RUN) && lu_raw;

  assign hif.freeze      = frz;
  assign hif.flush_if_id = br;
  assign hif.flush_id_ex = br | lu;
  assign hif.stall_pc    = lu;
  assign hif.stall_if_id = lu;

  always_comb begin
    sel_a = FWD_REG;
    sel_b = FWD_REG;
    if (trk_we[0] && trk_rd[0] != '0 && trk_rd[0] == hif.id_rs1)      sel_a = FWD_MEM;
    else if (trk_we[1] && trk_rd[1] != '0 && trk_rd[1] == hif.id_rs1) sel_a = FWD_WB;
    if (trk_we[0] && trk_rd[0] != '0 && trk_rd[0] == hif.id_rs2)      sel_b = FWD_MEM;
    else if (trk_we[1] && trk_rd[1] != '0 && trk_rd[1] == hif.id_rs2) sel_b = FWD_WB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_a_q <= FWD_REG;
      sel_b_q <= FWD_REG;
    end else if (!frz) begin
      if (hif.flush_id_ex || !hif.id_valid) begin
        sel_a_q <= FWD_REG;
        sel_b_q <= FWD_REG;
      end else begin
        sel_a_q <= sel_a;
        sel_b_q <= sel_b;
      end
    end
  end

  assign hif.fwd_a_sel = sel_a_q;
  assign hif.fwd_b_sel = sel_b_q;

  // A branch that resolves while frozen must still flush once the pipeline moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   br_pend <= 1'b0;
    else if (frz) br_pend <= br_pend | hif.ex_branch_taken;
    else          br_pend <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      prev_state <= RUN;
    end else if (frz) begin
      if (state != FROZEN) prev_state <= state;
      state <= FROZEN;
    end else begin
      state <= lu ? LD_STALL : RUN;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu && stall_cnt != '1) stall_cnt <= stall_cnt + PERF_W'(1);
      if (br && flush_cnt != '1) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end

  assign hif.perf_stall_cnt = stall_cnt;
  assign hif.perf_flush_cnt = flush_cnt;
`else
  assign hif.perf_stall_cnt = '0;
  assign hif.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed pipeline scenarios plus random traffic against an issue-history model of the scheduler.
module tb_hazard_scheduler;
  import hazard_pkg::*;

  localparam int AW   = 5;
  localparam int PW   = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scheduler_if #(.REG_AW(AW), .PERF_W(PW)) hif ();
  hazard_scheduler #(.REG_AW(AW), .PERF_W(PW)) dut (.clk(clk), .rst_n(rst_n), .hif(hif));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] rd;
    bit            we;
    bit            ld;
  } slot_t;

  // q[0] = instruction most recently issued into EX, q[1] = the one before it
  slot_t    q[$];
  bit       pend;
  logic [1:0] m_sa, m_sb;
  int       m_sc, m_fc;
  logic     o_stall, o_fii, o_fie, o_frz;
  logic [1:0] o_sa, o_sb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (rs != 0 && q[0].we && q[0].rd == rs) return 2'b10;
    if (rs != 0 && q[1].we && q[1].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    slot_t b;
    b = '{rd: '0, we: 1'b0, ld: 1'b0};
    q = {};
    q.push_back(b);
    q.push_back(b);
    pend = 0; m_sa = 0; m_sb = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                       input bit we, input bit ld, input bit br, input bit busy);
    hif.id_valid        = v;
    hif.id_rs1          = AW'(rs1);
    hif.id_rs2          = AW'(rs2);
    hif.id_rd           = AW'(rd);
    hif.id_reg_write    = we;
    hif.id_mem_read     = ld;
    hif.ex_branch_taken = br;
    hif.mem_busy        = busy;
  endtask

  task automatic cyc(input bit v, input int rs1, input int rs2, input int rd,
                     input bit we, input bit ld, input bit br, input bit busy);
    bit e_br, e_lu;
    slot_t s;
    logic [AW-1:0] r1, r2;
    @(negedge clk);
    drive(v, rs1, rs2, rd, we, ld, br, busy);
    r1 = AW'(rs1);
    r2 = AW'(rs2);
    #1;
    e_br = !busy && (br || pend);
    e_lu = !busy && !e_br && v && q[0].ld && q[0].we && q[0].rd != 0 &&
           (r1 == q[0].rd || r2 == q[0].rd);
    o_stall = hif.stall_pc; o_fii = hif.flush_if_id; o_fie = hif.flush_id_ex; o_frz = hif.freeze;
    chk("freeze", 32'(hif.freeze), 32'(busy));
    chk("flush_if_id", 32'(hif.flush_if_id), 32'(e_br));
    chk("flush_id_ex", 32'(hif.flush_id_ex), 32'(e_br | e_lu));
    chk("stall_pc", 32'(hif.stall_pc), 32'(e_lu));
    chk("stall_if_id", 32'(hif.stall_if_id), 32'(e_lu));
    if (busy) begin
      if (br) pend = 1;
    end else begin
      pend = 0;
      if (v && !e_br && !e_lu) begin
        m_sa = fwd(r1);
        m_sb = fwd(r2);
        s = '{rd: AW'(rd), we: we, ld: ld};
      end else begin
        m_sa = 0;
        m_sb = 0;
        s = '{rd: '0, we: 1'b0, ld: 1'b0};
      end
      q.push_front(s);
      void'(q.pop_back());
`ifdef HAZARD_PERF_EN
      if (e_lu && m_sc < PMAX) m_sc++;
      if (e_br && m_fc < PMAX) m_fc++;
`endif
    end
    @(posedge clk);
    #1;
    o_sa = hif.fwd_a_sel; o_sb = hif.fwd_b_sel;
    chk("fwd_a_sel", 32'(hif.fwd_a_sel), 32'(m_sa));
    chk("fwd_b_sel", 32'(hif.fwd_b_sel), 32'(m_sb));
    chk("perf_stall_cnt", 32'(hif.perf_stall_cnt), 32'(m_sc));
    chk("perf_flush_cnt", 32'(hif.perf_flush_cnt), 32'(m_fc));
  endtask

  // Asserts reset immediately, whatever the inputs are doing, then releases on an idle pipeline.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_stall_pc"}, 32'(hif.stall_pc), 0);
    chk({tag, "_stall_if_id"}, 32'(hif.stall_if_id), 0);
    chk({tag, "_flush_id_ex"}, 32'(hif.flush_id_ex), 0);
    chk({tag, "_flush_if_id"}, 32'(hif.flush_if_id), 0);
    @(posedge clk);
    #1;
    chk({tag, "_fwd_a"}, 32'(hif.fwd_a_sel), 0);
    chk({tag, "_fwd_b"}, 32'(hif.fwd_b_sel), 0);
    chk({tag, "_pstall"}, 32'(hif.perf_stall_cnt), 0);
    chk({tag, "_pflush"}, 32'(hif.perf_flush_cnt), 0);
    chk({tag, "_state"}, 32'(dut.state), 32'(RUN));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    do_reset("rst0");

    // back-to-back ALU dependency -> EX/MEM forward, no stall
    cyc(1, 1, 2, 5, 1, 0, 0, 0);
    cyc(1, 5, 1, 6, 1, 0, 0, 0);
    chk("d034_fwd_a", 32'(o_sa), 32'h2);
    chk("d034_stall", 32'(o_stall), 0);

    // one-gap dependency -> MEM/WB forward
    cyc(1, 1, 2, 5, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 2, 5, 7, 1, 0, 0, 0);
    chk("d035_fwd_b", 32'(o_sb), 32'h1);
    chk("d035_stall", 32'(o_stall), 0);

    // load-use: one stall bubble then MEM/WB forwards on both operands
    do_reset("rst1");
    cyc(1, 2, 0, 8, 1, 1, 0, 0);
    cyc(1, 8, 8, 9, 1, 0, 0, 0);
    chk("d036_stall", 32'(o_stall), 1);
    chk("d036_flush", 32'(o_fie), 1);
    chk("d036_bubble_a", 32'(o_sa), 0);
    cyc(1, 8, 8, 9, 1, 0, 0, 0);
    chk("d036_stall2", 32'(o_stall), 0);
    chk("d036_fwd_a", 32'(o_sa), 32'h1);
    chk("d036_fwd_b", 32'(o_sb), 32'h1);
`ifdef HAZARD_PERF_EN
    chk("d036_pcnt", 32'(hif.perf_stall_cnt), 1);
`else
    chk("d036_pcnt", 32'(hif.perf_stall_cnt), 0);
`endif

    // branch beats load-use
    cyc(1, 2, 0, 8, 1, 1, 0, 0);
    cyc(1, 8, 8, 9, 1, 0, 1, 0);
    chk("d037_fii", 32'(o_fii), 1);
    chk("d037_fie", 32'(o_fie), 1);
    chk("d037_stall", 32'(o_stall), 0);
    chk("d037_state", 32'(dut.state), 32'(RUN));

    // three-cycle freeze holds selects, then resumes
    cyc(1, 1, 2, 5, 1, 0, 0, 0);
    cyc(1, 5, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 6, 5, 7, 1, 0, 0, 1);
      chk("d038_freeze", 32'(o_frz), 1);
      chk("d038_hold_a", 32'(o_sa), 32'h2);
    end
    cyc(1, 6, 5, 7, 1, 0, 0, 0);
    chk("d038_resume_a", 32'(o_sa), 32'h2);
    chk("d038_resume_b", 32'(o_sb), 32'h1);

    // branch seen only while frozen must flush on the first free cycle
    cyc(1, 1, 2, 3, 1, 0, 1, 1);
    cyc(1, 1, 2, 3, 1, 0, 0, 0);
    chk("pend_fii", 32'(o_fii), 1);

    // x0 is never forwarded
    cyc(1, 1, 2, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 4, 1, 0, 0, 0);
    chk("d039_x0_a", 32'(o_sa), 0);
    chk("d039_x0_b", 32'(o_sb), 0);

    // reset while a load-use stall is being asserted
    cyc(1, 2, 0, 8, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 8, 8, 9, 1, 0, 0, 0);
    #1;
    chk("d039_pre_stall", 32'(hif.stall_pc), 1);
    do_reset("rst_mid");
    cyc(1, 8, 8, 9, 1, 0, 0, 0);
    chk("d039_no_residual", 32'(o_stall), 0);

    // random traffic over a small register set for dense hazards
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
          $urandom_range(0, 9) < 1, $urandom_range(0, 99) < 15);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter PERF_W, default 32, performance counter width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_rs1, id_rs2  in  REG_AW each  ID source registers.
REQ-007 id_rd  in  REG_AW  ID destination register.
REQ-008 id_reg_write  in  1  ID instruction writes rd.
REQ-009 id_mem_read  in  1  ID instruction is a load.
REQ-010 ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
REQ-011 mem_busy  in  1  data memory not ready; pipeline must freeze.
REQ-012 fwd_a_sel, fwd_b_sel  out  2 each  select codes for the EX operand 4:1 muxes, registered, valid while the instruction is in EX.
REQ-013 stall_pc, stall_if_id  out  1 each  hold PC and IF/ID.
REQ-014 flush_if_id, flush_id_ex  out  1 each  bubble the named pipeline register.
REQ-015 freeze  out  1  hold every pipeline register.
REQ-016 perf_stall_cnt, perf_flush_cnt  out  PERF_W each  event counters.

Function
REQ-017 Select encoding SHALL be: 00 register file, 01 MEM/WB result, 10 EX/MEM ALU result, 11 reserved and never driven.
REQ-018 Block SHALL track rd, reg_write and mem_read for the instructions in ID/EX and EX/MEM, shifting one stage per non-frozen cycle.
REQ-019 Per source operand: if it matches the ID/EX entry (reg_write=1, rd!=0), select 10; else if it matches the EX/MEM entry (reg_write=1, rd!=0), select 01; else 00; the nearer stage SHALL win.
REQ-020 Register x0 SHALL never be forwarded.
REQ-021 Load-use: if id_valid and the ID/EX entry is a load matching a used rs, assert stall_pc, stall_if_id and flush_id_ex for exactly 1 cycle; the re-evaluated instruction SHALL then get select 01.
REQ-022 Selects SHALL be latched when ID advances to EX; during a bubble the latched selects SHALL be 00.
REQ-023 ex_branch_taken SHALL assert flush_if_id and flush_id_ex in the same cycle (combinational) and clear the ID/EX tracking entry.
REQ-024 Branch flush SHALL take priority over load-use stall; stall outputs are 0 during a flush.
REQ-025 mem_busy SHALL assert freeze combinationally; while frozen, tracking, selects and FSM SHALL hold and stall/flush outputs SHALL be 0.
REQ-026 A flush or stall request arriving while frozen SHALL be evaluated on the first unfrozen cycle, not lost.
REQ-027 FSM states: RUN, LD_STALL, FROZEN. RUN->LD_STALL on load-use; LD_STALL->RUN after 1 cycle; any->FROZEN on mem_busy; FROZEN->previous state when mem_busy=0.

Reset
REQ-028 On rst_n=0, state SHALL be RUN, tracking entries invalid, fwd selects 00, counters 0, all stall/flush outputs 0.
REQ-029 Reset deassertion mid-operation SHALL resume from RUN with no residual stall.

Configuration
REQ-030 With HAZARD_PERF_EN defined, perf_stall_cnt SHALL count load-use stall cycles and perf_flush_cnt branch flushes, both saturating at all-ones.
REQ-031 Without HAZARD_PERF_EN, both counter ports SHALL exist and be driven constant 0, with no counter flops.

Structure
REQ-032 Select codes (FWD_REG, FWD_WB, FWD_MEM, FWD_RSVD) and FSM state encodings SHALL live in shared package hazard_pkg.
REQ-033 Stage tracking SHALL be sub-module hazard_stage_track (2-entry rd/reg_write/mem_read shift register with hold and clear).

Verification
REQ-034 add x5 then add x6,x5,x1 back-to-back -> fwd_a_sel=10 in EX of second, no stall.
REQ-035 add x5, nop, sub x7,x2,x5 -> fwd_b_sel=01, no stall.
REQ-036 lw x8 then add x9,x8,x8 -> one stall cycle, flush_id_ex=1 once, then fwd_a_sel=fwd_b_sel=01; perf_stall_cnt=1 with HAZARD_PERF_EN.
REQ-037 Load-use coinciding with ex_branch_taken=1 -> flush_if_id=flush_id_ex=1, stall_pc=0, FSM stays RUN.
REQ-038 mem_busy=1 for 3 cycles mid-sequence -> freeze=1 for 3 cycles, selects unchanged, sequence resumes identically.
REQ-039 Writes to x0 followed by readers of x0 -> selects 00; rst_n pulse mid-stall -> all outputs 0 next edge.
